jtag_dmi_master: RTL and testbench

- Synthesizable JTAG bit-bang master. Drives the SoC's jtag_TCK/TMS/TDI pins and samples jtag_TDO.
- Takes one command at a time (TAP reset, IR scan, DR scan) over a valid/ready handshake and walks the TAP state machine from Run-Test/Idle back to Run-Test/Idle.
- Returns the captured TDO bits as a one-cycle response.
- Sits directly upstream of the SoC JTAG port. It replaces hand-written TMS/TDI sequences in benches and lets an on-chip agent issue DMI reads and writes.

---
 rtl/jtag_dmi_master.sv | 181 ++++++++++++++++++
 tb/tb_jtag_dmi_master.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_dmi_master.sv
`default_nettype none
// ============================================================================
// jtag_dmi_master : JTAG bit-bang master (TAP reset / IR scan / DR scan)
// Revision: 1.0
// ============================================================================
module jtag_dmi_master #(
    parameter int TCK_DIV = 5,
    parameter int IR_LEN  = 5,
    parameter int DR_LEN  = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_cmd,
    input  logic [DR_LEN-1:0] req_data,
    output logic              rsp_valid,
    output logic [DR_LEN-1:0] rsp_data,
    output logic              jtag_TCK,
    output logic              jtag_TMS,
    output logic              jtag_TDI,
    input  logic              jtag_TDO
);
    localparam int         c_CNT_W   = $clog2(DR_LEN + 6);
    localparam logic [7:0] c_PH_LAST = 8'(TCK_DIV - 1);
    localparam logic [1:0] c_CMD_RST = 2'b00;
    localparam logic [1:0] c_CMD_IR  = 2'b01;
    localparam logic [1:0] c_CMD_DR  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RESET_SEQ = 3'd1,
        S_SEL       = 3'd2,
        S_CAPTURE   = 3'd3,
        S_SHIFT     = 3'd4,
        S_EXIT_UPD  = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic                is_ir_q, is_ir_d;
    logic [7:0]          phase_q, phase_d;
    logic [c_CNT_W-1:0]  cnt_q, cnt_d;
    logic                tck_q, tck_d;
    logic                tms_q, tms_d;
    logic                tdi_q, tdi_d;
    logic [DR_LEN-1:0]   sr_q, sr_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DR_LEN-1:0]   rsp_data_q, rsp_data_d;
    logic                w_load;
    logic                w_slot_end;

    function automatic logic [c_CNT_W-1:0] shift_last(input logic ir);
        return ir ? c_CNT_W'(IR_LEN - 1) : c_CNT_W'(DR_LEN - 1);
    endfunction

    always_comb begin
        state_d     = state_q;
        is_ir_d     = is_ir_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        tck_d       = tck_q;
        tms_d       = tms_q;
        tdi_d       = tdi_q;
        sr_d        = sr_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        w_load      = 1'b0;
        w_slot_end  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    phase_d     = '0;
                    tck_d       = 1'b0;
                    cnt_d       = '0;
                    is_ir_d     = (req_cmd == c_CMD_IR);
                    w_load      = 1'b1;
                    case (req_cmd)
                        c_CMD_RST: begin state_d = S_RESET_SEQ; sr_d = '0; end
                        c_CMD_IR:  begin state_d = S_SEL; sr_d = DR_LEN'(req_data[IR_LEN-1:0]); end
                        c_CMD_DR:  begin state_d = S_SEL; sr_d = req_data; end
                        default:   begin state_d = S_DONE; sr_d = '0; end
                    endcase
                end
            end
            S_DONE: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b1;
                rsp_data_d  = sr_q;
                req_ready_d = 1'b1;
            end
            default: begin
                if (phase_q == c_PH_LAST) begin
                    phase_d = '0;
                    tck_d   = ~tck_q;
                    // End of the low phase: TDO is sampled just before TCK rises
                    if (!tck_q && state_q == S_SHIFT) begin
                        if (is_ir_q) begin
                            sr_d             = sr_q >> 1;
                            sr_d[IR_LEN-1]   = jtag_TDO;
                        end else begin
                            sr_d = {jtag_TDO, sr_q[DR_LEN-1:1]};
                        end
                    end
                    w_slot_end = tck_q;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
                if (w_slot_end) begin
                    w_load = 1'b1;
                    cnt_d  = cnt_q + c_CNT_W'(1);
                    case (state_q)
                        S_RESET_SEQ: if (cnt_q == c_CNT_W'(5)) begin state_d = S_DONE; cnt_d = '0; end
                        S_SEL:       if (cnt_q == c_CNT_W'(is_ir_q)) begin state_d = S_CAPTURE; cnt_d = '0; end
                        S_CAPTURE:   if (cnt_q == c_CNT_W'(1)) begin state_d = S_SHIFT; cnt_d = '0; end
                        S_SHIFT:     if (cnt_q == shift_last(is_ir_q)) begin state_d = S_EXIT_UPD; cnt_d = '0; end
                        S_EXIT_UPD:  if (cnt_q == c_CNT_W'(1)) begin state_d = S_DONE; cnt_d = '0; end
                        default: ;
                    endcase
                end
            end
        endcase

        // TMS/TDI change only at the first cycle of a slot's low phase
        if (w_load) begin
            tms_d = 1'b0;
            tdi_d = 1'b0;
            case (state_d)
                S_RESET_SEQ: tms_d = (cnt_d != c_CNT_W'(5));
                S_SEL:       tms_d = 1'b1;
                S_SHIFT: begin
                    tms_d = (cnt_d == shift_last(is_ir_d));
                    tdi_d = sr_d[0];
                end
                S_EXIT_UPD:  tms_d = (cnt_d == '0);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            is_ir_q     <= 1'b0;
            phase_q     <= '0;
            cnt_q       <= '0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b0;
            tdi_q       <= 1'b0;
            sr_q        <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            is_ir_q     <= is_ir_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            tck_q       <= tck_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            sr_q        <= sr_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign jtag_TCK  = tck_q;
    assign jtag_TMS  = tms_q;
    assign jtag_TDI  = tdi_q;

endmodule
`default_nettype wire

// File: tb/tb_jtag_dmi_master.sv
`default_nettype none
// ============================================================================
// tb_jtag_dmi_master : randomized bench with a behavioural JTAG TAP model
// Revision: 1.0
// ============================================================================
module tb_jtag_dmi_master;
    localparam int D      = 3;
    localparam int IR_LEN = 5;
    localparam int DR_LEN = 40;
    localparam logic [1:0] c_RST = 2'b00, c_IR = 2'b01, c_DR = 2'b10, c_NOP = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0;
    logic req_ready;
    logic [1:0] req_cmd = 2'b00;
    logic [DR_LEN-1:0] req_data = '0;
    logic rsp_valid;
    logic [DR_LEN-1:0] rsp_data;
    logic jtag_TCK, jtag_TMS, jtag_TDI;
    logic jtag_TDO = 1'b0;

    logic req_valid_1 = 1'b0;
    logic req_ready_1;
    logic [1:0] req_cmd_1 = 2'b00;
    logic [DR_LEN-1:0] req_data_1 = '0;
    logic rsp_valid_1;
    logic [DR_LEN-1:0] rsp_data_1;
    logic tck_1, tms_1, tdi_1;
    logic tdo_1 = 1'b0;

    always #5 clk = ~clk;

    jtag_dmi_master #(.TCK_DIV(D), .IR_LEN(IR_LEN), .DR_LEN(DR_LEN)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_data(req_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS), .jtag_TDI(jtag_TDI), .jtag_TDO(jtag_TDO)
    );

    jtag_dmi_master #(.TCK_DIV(1), .IR_LEN(IR_LEN), .DR_LEN(DR_LEN)) u_dut_div1 (
        .clk(clk), .rst(rst), .req_valid(req_valid_1), .req_ready(req_ready_1),
        .req_cmd(req_cmd_1), .req_data(req_data_1), .rsp_valid(rsp_valid_1), .rsp_data(rsp_data_1),
        .jtag_TCK(tck_1), .jtag_TMS(tms_1), .jtag_TDI(tdi_1), .jtag_TDO(tdo_1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Standard IEEE 1149.1 TAP controller with one IR and one loopback DR
    typedef enum int {TLR, RTI, SDR, CDR, SHDR, E1DR, PDR, E2DR, UDR,
                      SIR, CIR, SHIR, E1IR, PIR, E2IR, UIR} tap_t;

    function automatic tap_t tap_next(input tap_t s, input logic tms);
        case (s)
            TLR:  return tms ? TLR  : RTI;
            RTI:  return tms ? SDR  : RTI;
            SDR:  return tms ? SIR  : CDR;
            CDR:  return tms ? E1DR : SHDR;
            SHDR: return tms ? E1DR : SHDR;
            E1DR: return tms ? UDR  : PDR;
            PDR:  return tms ? E2DR : PDR;
            E2DR: return tms ? UDR  : SHDR;
            UDR:  return tms ? SDR  : RTI;
            SIR:  return tms ? TLR  : CIR;
            CIR:  return tms ? E1IR : SHIR;
            SHIR: return tms ? E1IR : SHIR;
            E1IR: return tms ? UIR  : PIR;
            PIR:  return tms ? E2IR : PIR;
            E2IR: return tms ? UIR  : SHIR;
            default: return tms ? SDR : RTI;
        endcase
    endfunction

    tap_t tap = TLR;
    logic [DR_LEN-1:0] dr_preload = '0;
    logic [DR_LEN-1:0] dr_sh = '0;
    logic [DR_LEN-1:0] dr_upd = '0;
    int dr_upd_cnt = 0;
    logic [IR_LEN-1:0] ir_cap = 5'b00001;
    logic [IR_LEN-1:0] ir_sh = '0;
    logic [IR_LEN-1:0] ir_reg = '0;
    logic tms_log[$];
    logic tdi_log[$];
    logic tms1_log[$];
    logic tdi1_log[$];

    always @(jtag_TCK) begin
        if (jtag_TCK) begin
            tms_log.push_back(jtag_TMS);
            tdi_log.push_back(jtag_TDI);
            case (tap)
                TLR:  ir_reg = 5'h01;
                CDR:  dr_sh = dr_preload;
                SHDR: dr_sh = {jtag_TDI, dr_sh[DR_LEN-1:1]};
                UDR:  begin dr_upd = dr_sh; dr_upd_cnt++; end
                CIR:  ir_sh = ir_cap;
                SHIR: ir_sh = {jtag_TDI, ir_sh[IR_LEN-1:1]};
                UIR:  ir_reg = ir_sh;
                default: ;
            endcase
            tap = tap_next(tap, jtag_TMS);
            // TDO is only guaranteed valid while TCK is low
            jtag_TDO = 1'($urandom);
        end else begin
            jtag_TDO = (tap == SHDR) ? dr_sh[0] : (tap == SHIR) ? ir_sh[0] : 1'b0;
        end
    end

    always @(posedge tck_1) begin
        tms1_log.push_back(tms_1);
        tdi1_log.push_back(tdi_1);
    end

    function automatic void build_exp(input logic [1:0] cmd, input logic [DR_LEN-1:0] data,
                                      output logic [63:0] tms, output logic [63:0] tdi, output int s);
        int n;
        int len;
        tms = '0;
        tdi = '0;
        s   = 0;
        case (cmd)
            c_RST: begin tms[5:0] = 6'b011111; s = 6; end
            c_IR, c_DR: begin
                if (cmd == c_IR) begin tms[0] = 1'b1; tms[1] = 1'b1; n = 4; len = IR_LEN; end
                else begin tms[0] = 1'b1; n = 3; len = DR_LEN; end
                for (int i = 0; i < len; i++) begin
                    tdi[n] = data[i];
                    tms[n] = (i == len - 1);
                    n++;
                end
                tms[n] = 1'b1;
                s = n + 2;
            end
            default: s = 0;
        endcase
    endfunction

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!req_ready && n < 5000) begin @(negedge clk); n++; end
        check_eq({tag, "_ready"}, 64'(req_ready), 64'd1);
    endtask

    task automatic issue(input logic [1:0] cmd, input logic [DR_LEN-1:0] data, input string tag);
        int base, lat, s;
        logic [63:0] e_tms, e_tdi, o_tms, o_tdi;
        logic [DR_LEN-1:0] e_rsp;
        wait_ready(tag);
        base = tms_log.size();
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_data  = data;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_cmd   = 2'($urandom);
        req_data  = {8'($urandom), 32'($urandom)};
        check_eq({tag, "_busy"}, 64'(req_ready), 64'd0);
        lat = 0;
        while (!rsp_valid && lat < 4000) begin @(negedge clk); lat++; end
        build_exp(cmd, data, e_tms, e_tdi, s);
        case (cmd)
            c_IR:    e_rsp = DR_LEN'(ir_cap);
            c_DR:    e_rsp = dr_preload;
            default: e_rsp = '0;
        endcase
        check_eq({tag, "_latency"}, 64'(lat), 64'(s * 2 * D + 1));
        check_eq({tag, "_rsp_data"}, 64'(rsp_data), 64'(e_rsp));
        check_eq({tag, "_ready_back"}, 64'(req_ready), 64'd1);
        check_eq({tag, "_tck_idle"}, 64'(jtag_TCK), 64'd0);
        check_eq({tag, "_slots"}, 64'(tms_log.size() - base), 64'(s));
        o_tms = '0;
        o_tdi = '0;
        for (int i = 0; i < s && i < 64; i++) begin
            if (base + i < tms_log.size()) begin
                o_tms[i] = tms_log[base + i];
                o_tdi[i] = tdi_log[base + i];
            end
        end
        check_eq({tag, "_tms"}, o_tms, e_tms);
        check_eq({tag, "_tdi"}, o_tdi, e_tdi);
        check_eq({tag, "_tap_rti"}, 64'(tap == RTI), 64'd1);
        case (cmd)
            c_IR:  check_eq({tag, "_ir_reg"}, 64'(ir_reg), 64'(data[IR_LEN-1:0]));
            c_DR:  check_eq({tag, "_dr_upd"}, 64'(dr_upd), 64'(data));
            c_RST: check_eq({tag, "_ir_idcode"}, 64'(ir_reg), 64'h01);
            default: ;
        endcase
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        check_eq({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check_eq({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
        check_eq({tag, "_tck"}, 64'(jtag_TCK), 64'd0);
        check_eq({tag, "_tms"}, 64'(jtag_TMS), 64'd0);
        check_eq({tag, "_tdi"}, 64'(jtag_TDI), 64'd0);
    endtask

    task automatic run_div1();
        int lat, base;
        logic [63:0] o_tms, o_tdi;
        check_eq("div1_ready", 64'(req_ready_1), 64'd1);
        base = tms1_log.size();
        req_valid_1 = 1'b1;
        req_cmd_1   = c_RST;
        req_data_1  = {8'($urandom), 32'($urandom)};
        @(posedge clk);
        @(negedge clk);
        req_valid_1 = 1'b0;
        lat = 0;
        while (!rsp_valid_1 && lat < 500) begin @(negedge clk); lat++; end
        check_eq("div1_latency", 64'(lat), 64'd13);
        check_eq("div1_rsp_data", 64'(rsp_data_1), 64'd0);
        check_eq("div1_slots", 64'(tms1_log.size() - base), 64'd6);
        o_tms = '0;
        o_tdi = '0;
        for (int i = 0; i < 6; i++) begin
            if (base + i < tms1_log.size()) begin
                o_tms[i] = tms1_log[base + i];
                o_tdi[i] = tdi1_log[base + i];
            end
        end
        check_eq("div1_tms", o_tms, 64'b011111);
        check_eq("div1_tdi", o_tdi, 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, lat, n, seen, upd0;
        logic [1:0] cmd;
        logic [DR_LEN-1:0] data;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset");

        run_div1();

        ir_cap = 5'b00001;
        issue(c_RST, '0, "tap_reset");
        issue(c_IR, 40'h11, "ir_scan");
        dr_preload = 40'hA5_1234_5678;
        issue(c_DR, {6'h10, 32'h0, 2'b10}, "dr_scan");
        repeat (5) @(negedge clk);
        check_eq("rsp_hold", 64'(rsp_data), 64'hA5_1234_5678);

        // Request held high through a DR scan, then a no-op in the response cycle
        wait_ready("hold");
        base = tms_log.size();
        upd0 = dr_upd_cnt;
        dr_preload = {8'($urandom), 32'($urandom)};
        req_valid = 1'b1;
        req_cmd   = c_DR;
        req_data  = {8'($urandom), 32'($urandom)};
        @(posedge clk);
        @(negedge clk);
        lat = 0;
        while (!rsp_valid && lat < 4000) begin @(negedge clk); lat++; end
        check_eq("hold_latency", 64'(lat), 64'((5 + DR_LEN) * 2 * D + 1));
        req_cmd = c_NOP;
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("hold_nop_gap", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check_eq("hold_nop_rsp", 64'(rsp_valid), 64'd1);
        check_eq("hold_nop_data", 64'(rsp_data), 64'd0);
        repeat (10) @(negedge clk);
        check_eq("hold_one_dr", 64'(dr_upd_cnt - upd0), 64'd1);
        check_eq("hold_slots", 64'(tms_log.size() - base), 64'(5 + DR_LEN));

        // Reset in the middle of a DR scan
        wait_ready("midrst");
        base = tms_log.size();
        req_valid = 1'b1;
        req_cmd   = c_DR;
        req_data  = {8'($urandom), 32'($urandom)};
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (tms_log.size() - base < 20 && n < 2000) begin @(negedge clk); n++; end
        check_eq("midrst_slot20", 64'(tms_log.size() - base), 64'd20);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("midrst");
        base = tms_log.size();
        seen = 0;
        repeat (300) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check_eq("midrst_no_rsp", 64'(seen), 64'd0);
        check_eq("midrst_no_tck", 64'(tms_log.size() - base), 64'd0);
        issue(c_RST, '0, "post_rst_tap");
        issue(c_IR, {8'($urandom), 32'($urandom)}, "post_rst_ir");

        for (int r = 0; r < 16; r++) begin
            cmd        = 2'($urandom_range(0, 3));
            data       = {8'($urandom), 32'($urandom)};
            ir_cap     = 5'($urandom);
            dr_preload = {8'($urandom), 32'($urandom)};
            issue(cmd, data, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
